// File: rtl/eth_clk_pkg.sv
// Shared types and constants for the Ethernet clock/reset sequencer.
package eth_clk_pkg;

  typedef enum logic [1:0] {
    RESET     = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } rst_seq_st_t;

  localparam int LOSS_CNT_W = 16;

  // Counter width able to hold 0..limit-1, never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/sync_ff_eth.sv
// Multi-flop synchronizer bringing a single asynchronous bit into the clk_in domain.
module sync_ff_eth #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_rst_seq_eth.sv
// Reset sequencer: filters PLL lock, then releases N_RST resets in staged order.
// Optional lock-loss event counter enabled with `define ETH_CLK_LOSS_CNT_EN.
module clk_rst_seq_eth
  import eth_clk_pkg::*;
#(
  parameter int N_RST            = 3,
  parameter int SYNC_STAGES      = 2,
  parameter int LOCK_FILT_CYCLES = 1024,
  parameter int STAGE_DELAY      = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  pll_locked_i,
  input  logic                  rst_req_i,
  output logic [N_RST-1:0]      rst_out,
  output logic                  all_ready_o,
  output logic [1:0]            state_o,
  output logic                  lock_lost_o,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt_o
);

  localparam int FILT_W  = cnt_w(LOCK_FILT_CYCLES);
  localparam int DLY_W   = cnt_w(STAGE_DELAY);
  localparam int STAGE_W = cnt_w(N_RST);

  localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(LOCK_FILT_CYCLES - 1);
  localparam logic [DLY_W-1:0]   DLY_LAST   = DLY_W'(STAGE_DELAY - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_RST - 1);

  logic locked_s;

  sync_ff_eth #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_i    (pll_locked_i),
    .q_o    (locked_s)
  );

  rst_seq_st_t        state_q, state_d;
  logic [FILT_W-1:0]  filt_cnt_q, filt_cnt_d;
  logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic [STAGE_W-1:0] stage_idx_q, stage_idx_d;
  logic [N_RST-1:0]   rst_q, rst_d;
  logic               ready_q, ready_d;
  logic               lost_q, lost_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= RESET;
      filt_cnt_q  <= '0;
      dly_cnt_q   <= '0;
      stage_idx_q <= '0;
      rst_q       <= '1;
      ready_q     <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      filt_cnt_q  <= filt_cnt_d;
      dly_cnt_q   <= dly_cnt_d;
      stage_idx_q <= stage_idx_d;
      rst_q       <= rst_d;
      ready_q     <= ready_d;
      lost_q      <= lost_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    filt_cnt_d  = filt_cnt_q;
    dly_cnt_d   = dly_cnt_q;
    stage_idx_d = stage_idx_q;
    rst_d       = rst_q;
    ready_d     = ready_q;
    lost_d      = 1'b0;

    // Lock loss outranks a software request; both restart the lock filter.
    if ((state_q == RELEASE || state_q == RUN) && !locked_s) begin
      state_d    = WAIT_LOCK;
      filt_cnt_d = '0;
      rst_d      = '1;
      ready_d    = 1'b0;
      lost_d     = 1'b1;
    end else if (rst_req_i && state_q != RESET) begin
      state_d    = WAIT_LOCK;
      filt_cnt_d = '0;
      rst_d      = '1;
      ready_d    = 1'b0;
    end else begin
      unique case (state_q)
        RESET: begin
          state_d    = WAIT_LOCK;
          filt_cnt_d = '0;
        end
        WAIT_LOCK: begin
          if (!locked_s) begin
            filt_cnt_d = '0;
          end else if (filt_cnt_q == FILT_LAST) begin
            state_d     = RELEASE;
            stage_idx_d = '0;
            dly_cnt_d   = '0;
          end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (dly_cnt_q == DLY_LAST) begin
            rst_d[stage_idx_q] = 1'b0;
            stage_idx_d        = stage_idx_q + 1'b1;
            dly_cnt_d          = '0;
            if (stage_idx_q == STAGE_LAST) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end else begin
            dly_cnt_d = dly_cnt_q + 1'b1;
          end
        end
        RUN: begin
          rst_d   = '0;
          ready_d = 1'b1;
        end
        default: state_d = RESET;
      endcase
    end
  end

  assign rst_out     = rst_q;
  assign all_ready_o = ready_q;
  assign state_o     = state_q;
  assign lock_lost_o = lost_q;

`ifdef ETH_CLK_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q;

  // Counted on the same edge the pulse is raised; saturates instead of wrapping.
  always_ff @(posedge clk_in) begin
    if (rst_in)
      loss_cnt_q <= '0;
    else if (lost_d && loss_cnt_q != '1)
      loss_cnt_q <= loss_cnt_q + 1'b1;
  end

  assign lock_loss_cnt_o = loss_cnt_q;
`else
  assign lock_loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_clk_rst_seq_eth.sv
// Scoreboard bench: reference model pushes expected outputs each edge, monitor pops and compares.
module tb_clk_rst_seq_eth;

  localparam int N_RST = 3;
  localparam int SS    = 2;
  localparam int LF    = 8;
  localparam int SD    = 4;

  typedef struct packed {
    logic [N_RST-1:0] rst;
    logic             rdy;
    logic [1:0]       st;
    logic             lost;
    logic [15:0]      cnt;
  } obs_t;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic             pll_locked_i = 1'b0;
  logic             rst_req_i = 1'b0;
  logic [N_RST-1:0] rst_out;
  logic             all_ready_o;
  logic [1:0]       state_o;
  logic             lock_lost_o;
  logic [15:0]      lock_loss_cnt_o;

  clk_rst_seq_eth #(
    .N_RST(N_RST), .SYNC_STAGES(SS), .LOCK_FILT_CYCLES(LF), .STAGE_DELAY(SD)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .pll_locked_i    (pll_locked_i),
    .rst_req_i       (rst_req_i),
    .rst_out         (rst_out),
    .all_ready_o     (all_ready_o),
    .state_o         (state_o),
    .lock_lost_o     (lock_lost_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
  );

  always #5 clk_in = ~clk_in;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  obs_t exp_q[$];

  // Reference model state: phase 0..3, consecutive-lock run length,
  // cycles elapsed since RELEASE entry, and lock-loss event count.
  int m_phase = 0;
  int m_run   = 0;
  int m_t     = 0;
  int m_cnt   = 0;
  bit m_lost  = 0;
  bit hist[SS];

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got rst=%b rdy=%b st=%0d lost=%b cnt=%0d, expected rst=%b rdy=%b st=%0d lost=%b cnt=%0d",
               name, cyc, got.rst, got.rdy, got.st, got.lost, got.cnt,
               exp.rst, exp.rdy, exp.st, exp.lost, exp.cnt);
    end
  endtask

  task automatic model_step();
    bit   ls;
    obs_t e;
    if (rst_in) begin
      m_phase = 0; m_run = 0; m_t = 0; m_cnt = 0; m_lost = 0;
      for (int i = 0; i < SS; i++) hist[i] = 0;
    end else begin
      ls = hist[SS-1];
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = pll_locked_i;
      m_lost = 0;
      if (m_phase == 0) begin
        m_phase = 1; m_run = 0;
      end else if ((m_phase == 2 || m_phase == 3) && !ls) begin
        m_lost = 1; m_phase = 1; m_run = 0;
        if (m_cnt < 65535) m_cnt++;
      end else if (rst_req_i) begin
        m_phase = 1; m_run = 0;
      end else if (m_phase == 1) begin
        if (ls) begin
          m_run++;
          if (m_run == LF) begin m_phase = 2; m_t = 0; end
        end else m_run = 0;
      end else if (m_phase == 2) begin
        m_t++;
        if (m_t == N_RST * SD) m_phase = 3;
      end
    end
    for (int k = 0; k < N_RST; k++)
      e.rst[k] = (m_phase == 3) ? 1'b0 : (m_phase == 2) ? (m_t < (k + 1) * SD) : 1'b1;
    e.rdy  = (m_phase == 3);
    e.st   = 2'(m_phase);
    e.lost = m_lost;
`ifdef ETH_CLK_LOSS_CNT_EN
    e.cnt  = 16'(m_cnt);
`else
    e.cnt  = 16'h0;
`endif
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk_in);
    model_step();
  end

  initial forever begin
    obs_t got;
    obs_t exp;
    @(posedge clk_in);
    #1;
    cyc++;
    got = '{rst: rst_out, rdy: all_ready_o, st: state_o, lost: lock_lost_o, cnt: lock_loss_cnt_o};
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty cyc=%0d got st=%0d, expected an entry", cyc, got.st);
    end else begin
      exp = exp_q.pop_front();
      check("outputs", got, exp);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic lock_drop(input int n);
    pll_locked_i = 1'b0; cycles(n); pll_locked_i = 1'b1;
  endtask

  initial begin
    int hold;
    // Reset held 5 cycles, then lock held through a full release sequence.
    rst_in = 1'b1; pll_locked_i = 1'b0; rst_req_i = 1'b0;
    cycles(5);
    rst_in = 1'b0; pll_locked_i = 1'b1;
    cycles(35);
    // Lock loss in RUN, then re-sequence.
    lock_drop(1);
    cycles(35);
    // Software request in RUN.
    rst_req_i = 1'b1; cycles(1); rst_req_i = 1'b0;
    cycles(35);
    // Filter restart mid-count, then loss while only channel 0 is released.
    rst_in = 1'b1; cycles(3); rst_in = 1'b0;
    pll_locked_i = 1'b1; cycles(7);
    lock_drop(1);
    cycles(13);
    lock_drop(1);
    cycles(35);
    // rst_in coinciding with the detected lock loss.
    pll_locked_i = 1'b0; cycles(1);
    rst_in = 1'b1; cycles(3); rst_in = 1'b0;
    pll_locked_i = 1'b1; cycles(30);
    // Three losses, a software request, then rst_in.
    for (int i = 0; i < 3; i++) begin
      lock_drop(2);
      cycles(30);
    end
    rst_req_i = 1'b1; cycles(1); rst_req_i = 1'b0;
    cycles(30);
    rst_in = 1'b1; cycles(2); rst_in = 1'b0;
    cycles(5);
    // Randomized segments of lock/unlock with occasional requests and resets.
    for (int i = 0; i < 250; i++) begin
      pll_locked_i = ($urandom_range(0, 3) != 0);
      rst_req_i    = ($urandom_range(0, 7) == 0);
      rst_in       = ($urandom_range(0, 29) == 0);
      hold         = $urandom_range(1, 30);
      cycles(1);
      rst_req_i = 1'b0;
      rst_in    = 1'b0;
      cycles(hold);
    end
    cycles(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
